// File: rtl/gpmc_fifo_bridge.sv
// GPMC register map plus pixel FIFO; data_in registered one cycle behind the address, px stream from registered pointers.
// Pushes to a full FIFO are dropped and flagged as overflow; define GPMC_FIFO_IRQ_EN for the FIFO level threshold interrupt.
module gpmc_fifo_bridge #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH_LOG2 = 6,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE = 16'hCC01
) (
  input  logic                  gpmc_clk,
  input  logic                  rst,
  input  logic                  rd_en,
  input  logic                  wr_en,
  input  logic                  address_valid,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_out,
  output logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] px_data,
  output logic                  px_valid,
  input  logic                  px_ready,
  output logic                  irq
);

  localparam int PW    = FIFO_DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  localparam logic [3:0] A_ID      = 4'h0;
  localparam logic [3:0] A_CTRL    = 4'h1;
  localparam logic [3:0] A_STATUS  = 4'h2;
  localparam logic [3:0] A_FIFO    = 4'h3;
  localparam logic [3:0] A_SCRATCH = 4'h4;
  localparam logic [3:0] A_THRESH  = 4'h5;

  logic [3:0]            reg_addr;
  logic [1:0]            ctrl;
  logic [DATA_WIDTH-1:0] scratch;
  logic [DATA_WIDTH-1:0] thresh;
  logic                  overflow;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         level;
  logic                  empty;
  logic                  full;
  logic                  push_req;
  logic                  push;
  logic                  pop;
  logic                  flush;
  logic                  irq_bit;
  logic [DATA_WIDTH-1:0] status;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  unused_addr;

  assign unused_addr = ^address[ADDR_WIDTH-1:4];
  assign reg_addr    = address[3:0];

  assign flush = ctrl[1];
  assign level = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                 (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);

  assign px_valid = !empty;
  assign px_data  = mem[rd_ptr[PW-2:0]];
  assign pop      = px_valid && px_ready;

  // A pop in the same cycle frees the head slot, so a full FIFO still accepts the push.
  assign push_req = wr_en && (reg_addr == A_FIFO) && ctrl[0] && !flush;
  assign push     = push_req && (!full || pop);

`ifdef GPMC_FIFO_IRQ_EN
  assign irq_bit = irq;
`else
  assign irq_bit = 1'b0;
  assign irq     = 1'b0;
`endif

  always_comb begin
    status            = '0;
    status[PW-1:0]    = level;
    status[13]        = irq_bit;
    status[14]        = empty;
    status[15]        = overflow;
  end

  always_comb begin
    rd_data = '0;
    case (reg_addr)
      A_ID:      rd_data = ID_VALUE;
      A_CTRL:    rd_data[1:0] = ctrl;
      A_STATUS:  rd_data = status;
      A_SCRATCH: rd_data = scratch;
      A_THRESH:  rd_data = thresh;
      default:   rd_data = '0;
    endcase
  end

  always_ff @(posedge gpmc_clk) begin
    if (push) mem[wr_ptr[PW-2:0]] <= data_out;
  end

  always_ff @(posedge gpmc_clk or posedge rst) begin
    if (rst) begin
      ctrl     <= '0;
      scratch  <= '0;
      thresh   <= '0;
      overflow <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      data_in  <= '0;
    end else begin
      if (wr_en && reg_addr == A_CTRL) ctrl <= data_out[1:0];
      else                             ctrl[1] <= 1'b0;
      if (wr_en && reg_addr == A_SCRATCH) scratch <= data_out;
      if (wr_en && reg_addr == A_THRESH)  thresh  <= data_out;

      // A fresh overflow wins over a STATUS read in the same cycle.
      if (push_req && full && !pop)
        overflow <= 1'b1;
      else if (rd_en && address_valid && reg_addr == A_STATUS)
        overflow <= 1'b0;

      if (flush) begin
        rd_ptr <= wr_ptr;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end

      if (address_valid) data_in <= rd_data;
    end
  end

`ifdef GPMC_FIFO_IRQ_EN
  always_ff @(posedge gpmc_clk or posedge rst) begin
    if (rst) irq <= 1'b0;
    else     irq <= ctrl[0] && (level <= thresh[PW-1:0]);
  end
`endif

endmodule

// File: tb/tb_gpmc_fifo_bridge.sv
// Directed plus randomized bench for gpmc_fifo_bridge against a queue-based register/FIFO model.
module tb_gpmc_fifo_bridge;

  logic        gpmc_clk = 1'b0;
  logic        rst;
  logic        rd_en;
  logic        wr_en;
  logic        address_valid;
  logic [15:0] address;
  logic [15:0] data_out;
  logic [15:0] data_in;
  logic [15:0] px_data;
  logic        px_valid;
  logic        px_ready;
  logic        irq;

  int errors = 0;
  int checks = 0;

  logic [15:0] q[$];
  bit          m_en, m_flush, m_ovf, m_irq;
  logic [15:0] m_scratch, m_thresh, exp_din;

  gpmc_fifo_bridge dut (
    .gpmc_clk      (gpmc_clk),
    .rst           (rst),
    .rd_en         (rd_en),
    .wr_en         (wr_en),
    .address_valid (address_valid),
    .address       (address),
    .data_out      (data_out),
    .data_in       (data_in),
    .px_data       (px_data),
    .px_valid      (px_valid),
    .px_ready      (px_ready),
    .irq           (irq)
  );

  always #5 gpmc_clk = ~gpmc_clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_read(input logic [3:0] a);
    logic [15:0] s;
    s = '0;
    case (a)
      4'h0: s = 16'hCC01;
      4'h1: s = {14'b0, m_flush, m_en};
      4'h2: begin
        s[6:0] = 7'(q.size());
        s[13]  = m_irq;
        s[14]  = (q.size() == 0);
        s[15]  = m_ovf;
      end
      4'h4: s = m_scratch;
      4'h5: s = m_thresh;
      default: s = '0;
    endcase
    return s;
  endfunction

  task automatic model_reset();
    q.delete();
    m_en = 0; m_flush = 0; m_ovf = 0; m_irq = 0;
    m_scratch = '0; m_thresh = '0; exp_din = '0;
  endtask

  // Called just after a negedge with this cycle's inputs already driven.
  task automatic cycle();
    bit cur_flush, ovf_set, irq_next;
    logic [15:0] w;
    ovf_set = 0;
    if (address_valid) exp_din = model_read(address[3:0]);
`ifdef GPMC_FIFO_IRQ_EN
    irq_next = m_en && (q.size() <= int'(m_thresh[6:0]));
`else
    irq_next = 0;
`endif
    if (px_ready && q.size() != 0) begin
      w = q.pop_front();
      chk("px_data", px_data, w);
    end
    cur_flush = m_flush;
    m_flush = 0;
    if (wr_en) begin
      case (address[3:0])
        4'h1: begin m_en = data_out[0]; m_flush = data_out[1]; end
        4'h3: if (m_en && !cur_flush) begin
          if (q.size() < 64) q.push_back(data_out);
          else ovf_set = 1;
        end
        4'h4: m_scratch = data_out;
        4'h5: m_thresh = data_out;
        default: ;
      endcase
    end
    if (rd_en && address_valid && address[3:0] == 4'h2) m_ovf = 0;
    if (ovf_set) m_ovf = 1;
    if (cur_flush) q.delete();
    m_irq = irq_next;
    @(posedge gpmc_clk);
    @(negedge gpmc_clk);
    chk("px_valid", px_valid, 16'(q.size() != 0));
    chk("data_in", data_in, exp_din);
    chk("irq", irq, 16'(m_irq));
  endtask

  task automatic host_wr(input logic [3:0] a, input logic [15:0] d);
    address = {12'($urandom), a};
    address_valid = 1; data_out = d; wr_en = 1;
    cycle();
    wr_en = 0;
  endtask

  task automatic host_rd(input logic [3:0] a);
    address = {12'($urandom), a};
    address_valid = 1; rd_en = 1;
    cycle();
    rd_en = 0;
  endtask

  task automatic idle(input int n);
    address_valid = 0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    rst = 1; rd_en = 0; wr_en = 0; address_valid = 0;
    address = '0; data_out = '0; px_ready = 0;
    model_reset();
    @(negedge gpmc_clk);
    #1;
    chk("rst_px_valid", px_valid, 0);
    chk("rst_data_in", data_in, 0);
    chk("rst_irq", irq, 0);
    @(negedge gpmc_clk);
    rst = 0;

    host_rd(4'h0); chk("id", data_in, 16'hCC01);
    host_rd(4'h2); chk("status_rst", data_in, 16'h4000);
    host_rd(4'h4); chk("scratch_rst", data_in, 16'h0000);
    host_wr(4'h4, 16'hA5A5);
    host_rd(4'h4); chk("scratch_rw", data_in, 16'hA5A5);

    host_wr(4'h1, 16'h0001);
    for (int i = 1; i <= 3; i++) host_wr(4'h3, 16'(i));
    host_rd(4'h2); chk("level3", data_in, 16'h0003);
    px_ready = 1; address_valid = 0;
    for (int i = 1; i <= 3; i++) begin
      chk("drain_vld", px_valid, 1);
      chk("drain_dat", px_data, 16'(i));
      cycle();
    end
    chk("drain_empty", px_valid, 0);

    px_ready = 0;
    for (int i = 0; i < 65; i++) host_wr(4'h3, 16'($urandom));
    host_rd(4'h2); chk("ovf_set", data_in, 16'h8040);
    host_rd(4'h2); chk("ovf_clr", data_in, 16'h0040);

    px_ready = 1;
    for (int i = 0; i < 10; i++) host_wr(4'h3, 16'($urandom));
    px_ready = 0;
    host_rd(4'h2); chk("full_pushpop", data_in, 16'h0040);

    px_ready = 1;
    idle(70);
    chk("drained", px_valid, 0);
    px_ready = 0;

    host_wr(4'h5, 16'h0004);
    host_rd(4'h5); chk("thresh_rw", data_in, 16'h0004);
    for (int i = 0; i < 5; i++) host_wr(4'h3, 16'($urandom));
    host_wr(4'h1, 16'h0003);
    idle(1);
    chk("flush_vld", px_valid, 0);
    host_rd(4'h2); chk("flush_status", data_in, 16'h4000);
    host_rd(4'h1); chk("ctrl_after_flush", data_in, 16'h0001);
`ifdef GPMC_FIFO_IRQ_EN
    chk("irq_thresh", irq, 1);
`else
    chk("irq_tied", irq, 0);
`endif

    host_wr(4'h1, 16'h0000);
    host_wr(4'h3, 16'hBEEF);
    host_rd(4'h2); chk("disabled_push", data_in, 16'h4000);

    host_wr(4'h1, 16'h0001);
    for (int n = 0; n < 400; n++) begin
      int op;
      px_ready = ($urandom_range(0, 3) < ((n < 200) ? 1 : 3));
      op = $urandom_range(0, 9);
      case (op)
        0, 1:       idle(1);
        2, 3, 4, 5: host_wr(4'h3, 16'($urandom));
        6, 7:       host_rd(4'($urandom_range(0, 7)));
        8:          host_wr(($urandom_range(0, 1) != 0) ? 4'h4 : 4'h5, 16'($urandom_range(0, 80)));
        default:    host_wr(4'h1, 16'($urandom_range(1, 3)));
      endcase
    end

    px_ready = 0;
    host_wr(4'h1, 16'h0001);
    for (int i = 0; i < 3; i++) host_wr(4'h3, 16'($urandom));
    rst = 1;
    #1;
    chk("arst_px_valid", px_valid, 0);
    chk("arst_data_in", data_in, 0);
    model_reset();
    @(negedge gpmc_clk);
    rst = 0;
    host_rd(4'h2); chk("post_rst_status", data_in, 16'h4000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gpmc_fifo_bridge.md
Name: gpmc_fifo_bridge

Overview:
- Register/FIFO bridge directly downstream of the GPMC synchronous slave, in the gpmc_clk domain.
- Consumes the slave's host interface (rd_en, wr_en, address_valid, address, data_out) and drives its data_in read-back bus.
- Decodes a small register map, and pushes pixel words written by the host into a FIFO.
- The FIFO drains over a valid/ready stream to the LED driver.

Parameters:
ADDR_WIDTH, 16, host address width
DATA_WIDTH, 16, host data width and FIFO word width
FIFO_DEPTH_LOG2, 6, FIFO holds 2**FIFO_DEPTH_LOG2 words
ID_VALUE, 16'hCC01, constant returned by the ID register

Ports:
gpmc_clk  input  1  single clock, same clock as the GPMC slave
rst  input  1  asynchronous, active-high reset
rd_en  input  1  one-cycle read strobe from the GPMC slave
wr_en  input  1  one-cycle write strobe from the GPMC slave
address_valid  input  1  high while an address is latched
address  input  ADDR_WIDTH  latched word address
data_out  input  DATA_WIDTH  write data from the GPMC slave
data_in  output  DATA_WIDTH  read data back to the GPMC slave
px_data  output  DATA_WIDTH  FIFO head word
px_valid  output  1  FIFO not empty
px_ready  input  1  consumer accepts px_data when px_valid && px_ready
irq  output  1  level interrupt (see Optional Feature)

Behaviour:
- Reset: all registers, FIFO pointers and flags clear. data_in=0, px_valid=0, irq=0, CTRL=0, SCRATCH=0.
- Register map (word addresses; upper bits ignored, only address[3:0] decoded):
  - 0x0 ID: RO, ID_VALUE.
  - 0x1 CTRL: RW. bit0 = enable; bit1 = flush, self-clearing the next cycle.
  - 0x2 STATUS: RO. [FIFO_DEPTH_LOG2:0] = level; bit14 = empty; bit15 = sticky overflow, cleared on rd_en of STATUS.
  - 0x3 FIFO_DATA: WO push. Reads return 0.
  - 0x4 SCRATCH: RW.
  - 0x5 THRESH: RW. Readable and writable even when IRQ_EN is off.
  - Other addresses: reads return 0, writes are ignored.
- Read path: data_in is registered every cycle from the decoded address whenever address_valid=1, so it is valid one cycle after the address is latched. When address_valid=0, data_in holds its value. rd_en only triggers side effects (the STATUS clear).
- Writes take effect on the cycle wr_en is sampled high.
- FIFO push: wr_en && address==FIFO_DATA && CTRL.enable.
  - Push while full: word dropped, overflow set, level unchanged.
  - Push while enable=0: word dropped, no overflow.
- FIFO pop: px_valid && px_ready.
- Simultaneous push and pop: both occur, level unchanged; this is legal even when full (the pop frees the slot first).
- px_data/px_valid come from registered FIFO state. A word pushed at cycle N appears on px_valid no earlier than N+1.
- Pointers are FIFO_DEPTH_LOG2+1 bits wide, using the wrap-bit scheme. level = wr_ptr - rd_ptr, modulo 2**(FIFO_DEPTH_LOG2+1).
- Flush: pointers equalise on the cycle after the CTRL write. A push in the flush cycle is discarded. Overflow is not cleared by flush.
- Reset mid-operation: FIFO contents abandoned; px_valid drops asynchronously.

Optional Feature:
- Macro: GPMC_FIFO_IRQ_EN.
- Defined: irq = CTRL.enable && (level <= THRESH[FIFO_DEPTH_LOG2:0]), registered, one cycle latency. Also STATUS bit13 mirrors irq.
- Undefined: irq tied 0, STATUS bit13 reads 0, THRESH still a plain RW register.

Test Plan:
- Reset, then read addresses 0x0, 0x2, 0x4 -> data_in = 16'hCC01, 16'h4000 (empty), 16'h0000.
- Write SCRATCH=16'hA5A5, read it back -> data_in = 16'hA5A5 one cycle after address_valid.
- CTRL=1, push 3 words 0x0001..0x0003 with px_ready=0 -> STATUS level=3. Then px_ready=1 -> px_data 1,2,3 on consecutive cycles, then px_valid=0.
- CTRL=1, push 65 words with px_ready=0 (depth 64) -> level=64, STATUS bit15=1. Reading STATUS clears bit15. The 65th word is never emitted.
- Full FIFO, simultaneous push and pop for 10 cycles -> level stays 64, overflow stays 0, output order preserved.
- Write CTRL=3 with 5 words queued -> next cycle px_valid=0, level=0, CTRL reads 1. With GPMC_FIFO_IRQ_EN and THRESH=4 -> irq=1 one cycle later.
